// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace monitor.
// Holds the entry kind encodings, the trace entry field widths, the packed
// trace entry layout stored in the FIFO, and the default FIFO depth.
package trace_pkg;

  localparam int DEFAULT_DEPTH = 8;

  localparam int PC_W   = 32;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic KIND_REG = 1'b0;
  localparam logic KIND_MEM = 1'b1;

  typedef struct packed {
    logic              kind;
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/commit_fifo.sv
// Trace entry storage: circular buffer with two push slots and one pop per cycle.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   push0Valid_i/Entry_i first entry written this cycle
//   push1Valid_i/Entry_i second entry, written behind the first
//   pop_i                remove the head entry
//   headEntry_o          head entry, all zeros while empty
//   count_o              current occupancy
module commit_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push0Valid_i,
  input  trace_entry_t  push0Entry_i,
  input  logic          push1Valid_i,
  input  trace_entry_t  push1Entry_i,
  input  logic          pop_i,
  output trace_entry_t  headEntry_o,
  output logic [CW-1:0] count_o
);

  trace_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [CW-1:0] count_q;

  logic [AW-1:0] wrPtrNext1;
  logic [1:0]    pushN;
  logic          popEff;

  // The second slot always lands directly behind the first; the pointer wraps
  // naturally because DEPTH is a power of two.
  assign wrPtrNext1 = wrPtr_q + AW'(1);
  assign pushN      = {1'b0, push0Valid_i} + {1'b0, push1Valid_i};
  assign popEff     = pop_i && (count_q != '0);

  // Storage carries no reset; empty slots are masked on the read side.
  always_ff @(posedge clk) begin
    if (push0Valid_i) mem_q[wrPtr_q] <= push0Entry_i;
    if (push1Valid_i) mem_q[wrPtrNext1] <= push1Entry_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_q + AW'(pushN);
      rdPtr_q <= rdPtr_q + AW'(popEff);
      count_q <= count_q + CW'(pushN) - CW'(popEff);
    end
  end

  assign headEntry_o = (count_q != '0) ? mem_q[rdPtr_q] : '0;
  assign count_o     = count_q;

endmodule

// File: rtl/commit_trace_monitor.sv
// Commit trace monitor: turns CPU register and memory writes into a stream
// of trace entries buffered in a FIFO with a valid/ready consumer interface.
// Ports:
//   clk, reset                         clock, asynchronous active-low reset
//   PC                                 address of the committing instruction
//   RegWriteEn/Addr/Data               register-file write
//   MemWriteEn/Addr/Data               data-memory write
//   trace_valid/ready                  head handshake
//   trace_kind/pc/addr/data            head entry fields
//   count                              FIFO occupancy
//   overflow, drop_cnt                 sticky drop flag and saturating drop count
module commit_trace_monitor
  import trace_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   PC,
  input  logic              RegWriteEn,
  input  logic [REG_W-1:0]  RegWriteAddr,
  input  logic [DATA_W-1:0] RegWriteData,
  input  logic              MemWriteEn,
  input  logic [ADDR_W-1:0] MemWriteAddr,
  input  logic [DATA_W-1:0] MemWriteData,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic              trace_kind,
  output logic [PC_W-1:0]   trace_pc,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [DATA_W-1:0] trace_data,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  logic         memEv;
  logic         regEv;
  logic [1:0]   numEv;
  logic         pop;
  logic [CW:0]  space;
  logic         accept;
  logic [8:0]   dropSum;
  logic         overflow_q;
  logic [7:0]   dropCnt_q;
  logic [7:0]   dropCnt_d;

  trace_entry_t memEntry;
  trace_entry_t regEntry;
  trace_entry_t push0Entry;
  logic         push0Valid;
  logic         push1Valid;
  trace_entry_t headEntry;

  // Event formation; writes to $0 are architecturally void and never traced.
  // When both events occur the memory event takes the first slot.
  always_comb begin
    memEv      = MemWriteEn;
    regEv      = RegWriteEn && (RegWriteAddr != '0);
    numEv      = {1'b0, memEv} + {1'b0, regEv};
    memEntry   = '{kind: KIND_MEM, pc: PC, addr: MemWriteAddr, data: MemWriteData};
    regEntry   = '{kind: KIND_REG, pc: PC, addr: ADDR_W'(RegWriteAddr), data: RegWriteData};
    pop        = trace_valid && trace_ready;
    // A same-edge pop frees one slot for this cycle's events.
    space      = (CW+1)'(DEPTH) - {1'b0, count} + {{CW{1'b0}}, pop};
    accept     = {{(CW-1){1'b0}}, numEv} <= space;
    push0Valid = accept && (memEv || regEv);
    push0Entry = memEv ? memEntry : regEntry;
    push1Valid = accept && memEv && regEv;
    dropSum    = {1'b0, dropCnt_q} + {7'b0, numEv};
    dropCnt_d  = dropSum[8] ? 8'hFF : dropSum[7:0];
  end

  commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push0Valid_i (push0Valid),
    .push0Entry_i (push0Entry),
    .push1Valid_i (push1Valid),
    .push1Entry_i (regEntry),
    .pop_i        (pop),
    .headEntry_o  (headEntry),
    .count_o      (count)
  );

  // A cycle that does not fit is dropped as a whole; only reset clears the record.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      dropCnt_q  <= '0;
    end else if (!accept) begin
      overflow_q <= 1'b1;
      dropCnt_q  <= dropCnt_d;
    end
  end

  assign trace_valid = (count != '0);
  assign trace_kind  = headEntry.kind;
  assign trace_pc    = headEntry.pc;
  assign trace_addr  = headEntry.addr;
  assign trace_data  = headEntry.data;
  assign overflow    = overflow_q;
  assign drop_cnt    = dropCnt_q;

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Directed bench for commit_trace_monitor with hand-computed expectations.
module tb_commit_trace_monitor;

  logic        clk;
  logic        reset;
  logic [31:0] PC;
  logic        RegWriteEn;
  logic [4:0]  RegWriteAddr;
  logic [31:0] RegWriteData;
  logic        MemWriteEn;
  logic [31:0] MemWriteAddr;
  logic [31:0] MemWriteData;
  logic        trace_valid;
  logic        trace_ready;
  logic        trace_kind;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic [3:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  commit_trace_monitor #(.DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .PC           (PC),
    .RegWriteEn   (RegWriteEn),
    .RegWriteAddr (RegWriteAddr),
    .RegWriteData (RegWriteData),
    .MemWriteEn   (MemWriteEn),
    .MemWriteAddr (MemWriteAddr),
    .MemWriteData (MemWriteData),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_kind   (trace_kind),
    .trace_pc     (trace_pc),
    .trace_addr   (trace_addr),
    .trace_data   (trace_data),
    .count        (count),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one cycle's CPU write ports.
  task automatic applyStimulus(input logic [31:0] pc, input logic rwe, input logic [4:0] ra,
                               input logic [31:0] rd, input logic mwe, input logic [31:0] ma,
                               input logic [31:0] md);
    PC = pc; RegWriteEn = rwe; RegWriteAddr = ra; RegWriteData = rd;
    MemWriteEn = mwe; MemWriteAddr = ma; MemWriteData = md;
  endtask

  task automatic idle();
    applyStimulus(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] expData [8];
    reset = 1'b0;
    trace_ready = 1'b0;
    idle();
    #12;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_valid", 32'(trace_valid), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
    checkOutput("rst_data", trace_data, 32'd0);
    checkOutput("rst_pc", trace_pc, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Single register write, consumer ready.
    trace_ready = 1'b1;
    applyStimulus(32'h3000, 1'b1, 5'd8, 32'h12345678, 1'b0, 32'h0, 32'h0);
    tick();
    idle();
    checkOutput("r1_valid", 32'(trace_valid), 32'd1);
    checkOutput("r1_kind", 32'(trace_kind), 32'd0);
    checkOutput("r1_addr", trace_addr, 32'd8);
    checkOutput("r1_data", trace_data, 32'h12345678);
    checkOutput("r1_pc", trace_pc, 32'h3000);
    tick();
    checkOutput("r1_popped", 32'(count), 32'd0);
    checkOutput("r1_empty_data", trace_data, 32'd0);

    // Write to $0 is discarded.
    applyStimulus(32'h3004, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0);
    tick();
    idle();
    checkOutput("r0_count", 32'(count), 32'd0);
    checkOutput("r0_overflow", 32'(overflow), 32'd0);

    // Dual event: memory entry ahead of register entry.
    trace_ready = 1'b0;
    applyStimulus(32'h100, 1'b1, 5'd2, 32'hBB, 1'b1, 32'h4, 32'hAA);
    tick();
    idle();
    checkOutput("dual_count", 32'(count), 32'd2);
    checkOutput("dual_kind0", 32'(trace_kind), 32'd1);
    checkOutput("dual_addr0", trace_addr, 32'h4);
    checkOutput("dual_data0", trace_data, 32'hAA);
    checkOutput("dual_pc0", trace_pc, 32'h100);
    tick();
    checkOutput("dual_hold", trace_data, 32'hAA);
    trace_ready = 1'b1;
    tick();
    checkOutput("dual_count1", 32'(count), 32'd1);
    checkOutput("dual_kind1", 32'(trace_kind), 32'd0);
    checkOutput("dual_addr1", trace_addr, 32'h2);
    checkOutput("dual_data1", trace_data, 32'hBB);
    tick();
    checkOutput("dual_empty", 32'(count), 32'd0);
    tick();
    checkOutput("ready_idle", 32'(count), 32'd0);

    // Nine register writes into a depth-8 FIFO with no consumer.
    trace_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(32'h2000 + 32'(4 * i), 1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 32'h0, 32'h0);
      tick();
      checkOutput($sformatf("fill_count%0d", i), 32'(count), (i > 8) ? 32'd8 : 32'(i));
    end
    idle();
    checkOutput("fill_overflow", 32'(overflow), 32'd1);
    checkOutput("fill_drop", 32'(drop_cnt), 32'd1);
    checkOutput("fill_head", trace_data, 32'h101);

    // Full FIFO: push plus pop on the same edge is accepted.
    trace_ready = 1'b1;
    applyStimulus(32'h2040, 1'b1, 5'd10, 32'h10A, 1'b0, 32'h0, 32'h0);
    tick();
    idle();
    trace_ready = 1'b0;
    checkOutput("pp_count", 32'(count), 32'd8);
    checkOutput("pp_head", trace_data, 32'h102);
    checkOutput("pp_drop", 32'(drop_cnt), 32'd1);

    // Full FIFO, dual event, no consumer: both dropped.
    applyStimulus(32'h2044, 1'b1, 5'd11, 32'hDD, 1'b1, 32'h8000, 32'hCC);
    tick();
    idle();
    checkOutput("fd_count", 32'(count), 32'd8);
    checkOutput("fd_drop", 32'(drop_cnt), 32'd3);

    // Drain in arrival order.
    for (int k = 0; k < 7; k++) expData[k] = 32'h102 + 32'(k);
    expData[7] = 32'h10A;
    trace_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("drain_data%0d", k), trace_data, expData[k]);
      tick();
    end
    checkOutput("drain_count", 32'(count), 32'd0);
    checkOutput("drain_valid", 32'(trace_valid), 32'd0);
    checkOutput("drain_overflow", 32'(overflow), 32'd1);
    checkOutput("drain_drop", 32'(drop_cnt), 32'd3);

    // Asynchronous reset with five entries buffered.
    trace_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(32'h5000, 1'b1, 5'(i), 32'(i), 1'b0, 32'h0, 32'h0);
      tick();
    end
    checkOutput("ar_count5", 32'(count), 32'd5);
    reset = 1'b0;
    #1;
    checkOutput("ar_count", 32'(count), 32'd0);
    checkOutput("ar_valid", 32'(trace_valid), 32'd0);
    checkOutput("ar_overflow", 32'(overflow), 32'd0);
    checkOutput("ar_drop", 32'(drop_cnt), 32'd0);
    tick();
    checkOutput("ar_nosample", 32'(count), 32'd0);
    idle();
    reset = 1'b1;
    tick();

    // Saturation of the drop counter.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(32'h6000, 1'b1, 5'(i), 32'(i), 1'b0, 32'h0, 32'h0);
      tick();
    end
    applyStimulus(32'h6004, 1'b1, 5'd3, 32'h33, 1'b1, 32'h40, 32'h44);
    for (int i = 0; i < 130; i++) tick();
    idle();
    checkOutput("sat_drop", 32'(drop_cnt), 32'd255);
    checkOutput("sat_count", 32'(count), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
